// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data memory responder with stall/flush handshake
module dmem_responder #(
  parameter int LATENCY = 2,
  parameter int AW      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        pipe_stall_i,
  input  logic        flush_i,
  output logic [31:0] rdata_o,
  output logic        stall_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          req_we;
  logic [3:0]    req_sel;
  logic [AW-1:0] req_idx;
  logic [31:0]   req_wdata;
  logic [31:0]   mem [1<<AW];

  logic accept;
  logic access;
  logic unused_addr_bits;

  assign accept = (state == IDLE) && en_i && !flush_i;
  assign access = (state == BUSY) && (cnt == 4'd0) && !flush_i;
  assign unused_addr_bits = ^{addr_i[31:AW+2], addr_i[1:0]};

  always_comb begin
    stall_o = 1'b0;
    case (state)
      IDLE:    stall_o = en_i & ~flush_i;
      BUSY:    stall_o = ~flush_i;
      default: stall_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rdata_o   <= 32'd0;
      req_we    <= 1'b0;
      req_sel   <= 4'd0;
      req_idx   <= '0;
      req_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_we    <= we_i;
            req_sel   <= sel_i;
            req_idx   <= addr_i[AW+1:2];
            req_wdata <= wdata_i;
            cnt       <= 4'(LATENCY - 1);
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (flush_i) begin
            state <= IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // writes report zero so a stale read value never leaks to the pipeline
            rdata_o <= req_we ? 32'd0 : mem[req_idx];
            state   <= DONE;
          end
        end
        DONE: begin
          if (flush_i || !pipe_stall_i)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // storage is intentionally not reset; access is only true in BUSY, so reset blocks writes
  always_ff @(posedge clk) begin
    if (access && req_we) begin
      for (int i = 0; i < 4; i++) begin
        if (req_sel[i])
          mem[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;
  localparam int LAT = 2;
  localparam int AW  = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_i = 1'b0, we_i = 1'b0, pipe_stall_i = 1'b0, flush_i = 1'b0;
  logic [3:0]  sel_i = 4'd0;
  logic [31:0] addr_i = 32'd0, wdata_i = 32'd0;
  logic [31:0] rdata_o;
  logic        stall_o;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] ref_mem [int];

  dmem_responder #(.LATENCY(LAT), .AW(AW)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .we_i(we_i), .sel_i(sel_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .pipe_stall_i(pipe_stall_i), .flush_i(flush_i),
    .rdata_o(rdata_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  function automatic int widx(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] w;
    w = ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 32'd0;
    for (int i = 0; i < 4; i++)
      if (s[i]) w[8*i +: 8] = d[8*i +: 8];
    ref_mem[widx(a)] = w;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 32'd0;
  endfunction

  // Issues one request and reports what was observed; request inputs are scrambled once accepted.
  task automatic run_req(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold, output int scyc,
                         output logic [31:0] rd, output int hold_stalls, output int hold_changes);
    bit done;
    en_i = 1'b1; we_i = we; sel_i = sel; addr_i = addr; wdata_i = wdata;
    scyc = 0; hold_stalls = 0; hold_changes = 0; rd = 32'd0; done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (!stall_o) done = 1;
      else begin
        scyc++;
        @(posedge clk); #1;
        we_i = 1'($urandom); sel_i = 4'($urandom); addr_i = $urandom; wdata_i = $urandom;
      end
    end
    if (!done) scyc = -1;
    rd = rdata_o;
    pipe_stall_i = (hold > 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      if (stall_o) hold_stalls++;
      if (rdata_o !== rd) hold_changes++;
    end
    pipe_stall_i = 1'b0;
    @(posedge clk); #1;
    en_i = 1'b0; we_i = 1'b0; sel_i = 4'd0; addr_i = 32'd0; wdata_i = 32'd0;
  endtask

  task automatic test_reset;
    #2;
    tests_run++;
    if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got %0b want 0", stall_o); end
    tests_run++;
    if (rdata_o !== 32'd0) begin tests_failed++; $display("FAIL reset_rdata got %h want 0", rdata_o); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int sc, hs, hc; logic [31:0] rd;
    run_req(1'b1, 4'hF, 32'h40, 32'hDEADBEEF, 0, sc, rd, hs, hc);
    model_write(32'h40, 4'hF, 32'hDEADBEEF);
    tests_run++;
    if (sc !== LAT + 1) begin tests_failed++; $display("FAIL basic_wr_stall got %0d want %0d", sc, LAT + 1); end
    tests_run++;
    if (rd !== 32'd0) begin tests_failed++; $display("FAIL basic_wr_rdata got %h want 0", rd); end
    run_req(1'b0, 4'h0, 32'h40, 32'h0, 0, sc, rd, hs, hc);
    tests_run++;
    if (sc !== LAT + 1) begin tests_failed++; $display("FAIL basic_rd_stall got %0d want %0d", sc, LAT + 1); end
    tests_run++;
    if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL basic_rd_data got %h want deadbeef", rd); end
  endtask

  task automatic test_byte_lanes;
    int sc, hs, hc; logic [31:0] rd;
    run_req(1'b1, 4'hF, 32'h80, 32'h11223344, 0, sc, rd, hs, hc);
    model_write(32'h80, 4'hF, 32'h11223344);
    run_req(1'b1, 4'b0100, 32'h80, 32'h00AA0000, 0, sc, rd, hs, hc);
    model_write(32'h80, 4'b0100, 32'h00AA0000);
    run_req(1'b0, 4'h0, 32'h80, 32'h0, 0, sc, rd, hs, hc);
    tests_run++;
    if (rd !== 32'h11AA3344) begin tests_failed++; $display("FAIL byte_lane got %h want 11aa3344", rd); end
    run_req(1'b1, 4'b0000, 32'h80, 32'hFFFFFFFF, 0, sc, rd, hs, hc);
    tests_run++;
    if (sc !== LAT + 1) begin tests_failed++; $display("FAIL zero_sel_stall got %0d want %0d", sc, LAT + 1); end
    run_req(1'b0, 4'h0, 32'h80, 32'h0, 0, sc, rd, hs, hc);
    tests_run++;
    if (rd !== model_read(32'h80)) begin tests_failed++; $display("FAIL zero_sel_data got %h want %h", rd, model_read(32'h80)); end
  endtask

  task automatic test_alias;
    int sc, hs, hc; logic [31:0] rd;
    run_req(1'b1, 4'hF, 32'h00001004, 32'h12345678, 0, sc, rd, hs, hc);
    model_write(32'h00001004, 4'hF, 32'h12345678);
    run_req(1'b0, 4'h0, 32'h00000004, 32'h0, 0, sc, rd, hs, hc);
    tests_run++;
    if (rd !== 32'h12345678) begin tests_failed++; $display("FAIL alias got %h want 12345678", rd); end
  endtask

  task automatic test_pipe_stall;
    int sc, hs, hc; logic [31:0] rd;
    run_req(1'b0, 4'hF, 32'h40, 32'h0, 4, sc, rd, hs, hc);
    tests_run++;
    if (rd !== model_read(32'h40)) begin tests_failed++; $display("FAIL hold_rd_data got %h want %h", rd, model_read(32'h40)); end
    tests_run++;
    if (hs !== 0 || hc !== 0) begin tests_failed++; $display("FAIL hold_rd_stable got stalls=%0d changes=%0d want 0/0", hs, hc); end
    run_req(1'b1, 4'b0001, 32'h80, 32'h000000C3, 4, sc, rd, hs, hc);
    model_write(32'h80, 4'b0001, 32'h000000C3);
    tests_run++;
    if (hs !== 0 || hc !== 0 || sc !== LAT + 1) begin tests_failed++; $display("FAIL hold_wr got stalls=%0d changes=%0d sc=%0d want 0/0/%0d", hs, hc, sc, LAT + 1); end
    run_req(1'b0, 4'h0, 32'h80, 32'h0, 0, sc, rd, hs, hc);
    tests_run++;
    if (rd !== model_read(32'h80)) begin tests_failed++; $display("FAIL hold_wr_data got %h want %h", rd, model_read(32'h80)); end
  endtask

  task automatic test_flush;
    int sc, hs, hc, bad; logic [31:0] rd; bit done;
    run_req(1'b1, 4'hF, 32'h100, 32'hCAFE0001, 0, sc, rd, hs, hc);
    model_write(32'h100, 4'hF, 32'hCAFE0001);
    en_i = 1'b1; we_i = 1'b1; sel_i = 4'hF; addr_i = 32'h100; wdata_i = 32'hBAD0BAD0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush_i = 1'b1; #1;
    tests_run++;
    if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL flush_busy_stall got %0b want 0", stall_o); end
    @(posedge clk); #1;
    flush_i = 1'b0; en_i = 1'b0; we_i = 1'b0;
    tests_run++;
    if (rdata_o !== 32'd0) begin tests_failed++; $display("FAIL flush_busy_rdata got %h want 0", rdata_o); end
    run_req(1'b0, 4'h0, 32'h100, 32'h0, 0, sc, rd, hs, hc);
    tests_run++;
    if (sc !== LAT + 1 || rd !== 32'hCAFE0001) begin tests_failed++; $display("FAIL flush_busy_after got sc=%0d data=%h want %0d/cafe0001", sc, rd, LAT + 1); end
    // flush in IDLE must block acceptance
    en_i = 1'b1; we_i = 1'b1; sel_i = 4'hF; addr_i = 32'h100; wdata_i = 32'h0BADF00D; flush_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); if (stall_o) bad++;
      @(posedge clk); #1;
    end
    en_i = 1'b0; flush_i = 1'b0;
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL flush_idle_stall got %0d want 0", bad); end
    run_req(1'b0, 4'h0, 32'h100, 32'h0, 0, sc, rd, hs, hc);
    tests_run++;
    if (rd !== 32'hCAFE0001) begin tests_failed++; $display("FAIL flush_idle_data got %h want cafe0001", rd); end
    // flush in DONE forces IDLE even while the pipeline is stalled
    en_i = 1'b1; we_i = 1'b0; sel_i = 4'hF; addr_i = 32'h40;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk); if (!stall_o) done = 1; else begin @(posedge clk); #1; end
    end
    pipe_stall_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (stall_o !== 1'b1) begin tests_failed++; $display("FAIL flush_done_idle got stall=%0b want 1", stall_o); end
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (!stall_o) done = 1; else begin @(posedge clk); @(negedge clk); end
    end
    tests_run++;
    if (!done || rdata_o !== model_read(32'h40)) begin tests_failed++; $display("FAIL flush_done_data got %h want %h", rdata_o, model_read(32'h40)); end
    pipe_stall_i = 1'b0;
    @(posedge clk); #1;
    en_i = 1'b0;
  endtask

  task automatic test_reset_busy;
    int sc, hs, hc; logic [31:0] rd;
    run_req(1'b1, 4'hF, 32'h200, 32'h5A5A1234, 0, sc, rd, hs, hc);
    model_write(32'h200, 4'hF, 32'h5A5A1234);
    run_req(1'b0, 4'h0, 32'h200, 32'h0, 0, sc, rd, hs, hc);
    en_i = 1'b1; we_i = 1'b1; sel_i = 4'hF; addr_i = 32'h200; wdata_i = 32'h0;
    @(posedge clk); #3;
    rst = 1'b1; en_i = 1'b0; #1;
    tests_run++;
    if (stall_o !== 1'b0 || rdata_o !== 32'd0) begin tests_failed++; $display("FAIL rst_busy got stall=%0b rdata=%h want 0/0", stall_o, rdata_o); end
    @(posedge clk); @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    run_req(1'b0, 4'h0, 32'h200, 32'h0, 0, sc, rd, hs, hc);
    tests_run++;
    if (sc !== LAT + 1 || rd !== 32'h5A5A1234) begin tests_failed++; $display("FAIL rst_busy_after got sc=%0d data=%h want %0d/5a5a1234", sc, rd, LAT + 1); end
  endtask

  task automatic test_random;
    int sc, hs, hc; logic [31:0] rd, exp, a, d; logic [9:0] bases [8]; logic we; logic [3:0] s;
    for (int i = 0; i < 8; i++) begin
      bases[i] = {3'(i), 7'($urandom)};
      a = {20'($urandom), bases[i], 2'($urandom)};
      d = $urandom;
      run_req(1'b1, 4'hF, a, d, 0, sc, rd, hs, hc);
      model_write(a, 4'hF, d);
    end
    for (int n = 0; n < 24; n++) begin
      a = {20'($urandom), bases[$urandom_range(7)], 2'($urandom)};
      we = 1'($urandom); s = 4'($urandom); d = $urandom;
      exp = we ? 32'd0 : model_read(a);
      run_req(we, s, a, d, $urandom_range(2), sc, rd, hs, hc);
      if (we) model_write(a, s, d);
      tests_run++;
      if (sc !== LAT + 1 || rd !== exp || hs !== 0) begin
        tests_failed++;
        $display("FAIL random_%0d got sc=%0d data=%h hs=%0d want %0d/%h/0", n, sc, rd, hs, LAT + 1, exp);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_byte_lanes;
    test_alias;
    test_pipe_stall;
    test_flush;
    test_reset_busy;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, number of wait cycles spent in BUSY; legal range 1..15.
REQ-002 SHALL have parameter AW, default 10, log2 of the word depth; internal storage is 2^AW x 32 bits.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-005 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port en_i, input, 1 bit, data-memory request valid from the pipeline MEM stage.
REQ-007 SHALL have port we_i, input, 1 bit, 1 = write, 0 = read.
REQ-008 SHALL have port sel_i, input, 4 bits, byte-lane enables; bit n covers data bits 8n+7:8n.
REQ-009 SHALL have port addr_i, input, 32 bits, byte address.
REQ-010 SHALL have port wdata_i, input, 32 bits, lane-aligned write data.
REQ-011 SHALL have port pipe_stall_i, input, 1 bit, pipeline stall from sources other than this block.
REQ-012 SHALL have port flush_i, input, 1 bit, MEM-stage flush on exception.
REQ-013 SHALL have port rdata_o, output, 32 bits, full read word.
REQ-014 SHALL have port stall_o, output, 1 bit, stall request to the hazard unit (stallreq_from_mem).

Function
REQ-015 SHALL implement an FSM with states IDLE, BUSY and DONE, plus a 4-bit wait counter cnt.
REQ-016 IDLE: stall_o SHALL equal en_i & ~flush_i (combinational); on en_i & ~flush_i, SHALL latch we_i, sel_i, addr_i and wdata_i, load cnt = LATENCY-1, and go to BUSY.
REQ-017 BUSY: stall_o SHALL be 1; if cnt != 0, cnt SHALL decrement; if cnt == 0, the access SHALL be performed at that edge and the state SHALL go to DONE.
REQ-018 A request accepted in cycle T SHALL hold stall_o high for cycles T..T+LATENCY; DONE SHALL be entered at T+LATENCY+1.
REQ-019 Write access: only lanes with latched sel bit = 1 SHALL be updated at word index addr[AW+1:2]; bits 1:0 and bits above AW+1 SHALL be ignored.
REQ-020 Read access: rdata_o SHALL register the full word at index addr[AW+1:2], ignoring sel.
REQ-021 A write SHALL set rdata_o to 0.
REQ-022 DONE: stall_o SHALL be 0 and rdata_o SHALL hold its value.
REQ-023 DONE with pipe_stall_i = 1: the state SHALL stay DONE, and no new access SHALL occur even though en_i is still high for the same instruction.
REQ-024 DONE with pipe_stall_i = 0: the state SHALL go to IDLE at the next edge, so a back-to-back request is accepted one cycle after DONE.
REQ-025 flush_i in BUSY SHALL abort the access: no write, rdata_o unchanged, next state IDLE, and stall_o = 0 in that cycle.
REQ-026 flush_i in DONE SHALL force IDLE at the next edge.
REQ-027 flush_i in IDLE SHALL block request acceptance.
REQ-028 en_i = 1 with sel_i = 4'b0000 on a write SHALL run the full handshake and leave memory unchanged.
REQ-029 Request inputs are not sampled after IDLE; changes in BUSY or DONE SHALL have no effect.

Reset
REQ-030 rst = 1 SHALL immediately force state IDLE, cnt = 0, rdata_o = 0, stall_o = 0 (if en_i = 0) and clear the latched request registers, independent of clk.
REQ-031 Reset during BUSY SHALL abort the in-flight access, and no write SHALL occur.
REQ-032 Memory array contents SHALL NOT be reset.
REQ-033 Deassertion of rst SHALL be followed by normal operation at the first rising clk edge.

Verification
REQ-034 Write 0xDEADBEEF, sel 4'hF, addr 0x40, then read 0x40 with LATENCY = 2 -> each request has stall_o high for 3 cycles; the read gives rdata_o = 0xDEADBEEF in DONE.
REQ-035 Preload 0x11223344 at 0x80, write sel 4'b0100 with data 0x00AA0000, then read -> rdata_o = 0x11AA3344.
REQ-036 Read completes while pipe_stall_i = 1 for 4 cycles with en_i held -> the state stays DONE, no repeated access, and rdata_o is stable; a write in the same pattern updates exactly once.
REQ-037 Write to 0x100 with flush_i pulsed in the second BUSY cycle -> stall_o drops that cycle, a following read of 0x100 returns the old value, and the FSM returns to IDLE.
REQ-038 Assert rst mid-BUSY of a write -> stall_o = 0 and rdata_o = 0 immediately, the target word is unchanged, and the next request completes normally.
REQ-039 Address aliasing with AW = 10: write 0x12345678 to 0x00001004, then read 0x00000004 -> rdata_o = 0x12345678.
